mac_arbiter: RTL

- Shares one pipelined multiply-add unit (DATA = A*B + C, P-bit operands, 2P-bit result) between NREQ requesters.
- Round-robin valid/ready handshake on the request side; every operation carries a requester tag through the pipeline; each result returns with a one-hot strobe to the requester that issued it.
- Sits between the client blocks and the MAC datapath.
- A flush/drain control lets the system quiesce the unit before reconfiguration.

---
 rtl/mac_arbiter_pkg.sv | 29 ++
 rtl/mac_arbiter_pipe.sv | 96 +++++++++
 rtl/mac_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mac_arbiter_pkg.sv
// Shared types and constants for the MAC arbiter slice.
//   P        : operand width
//   NREQ_DEF : default requester count
//   LAT      : accept-to-result latency of mac_pipe (three register stages)
//   tag_t, opnd_t, res_t, arb_state_t : common typedefs
//   mac_calc : unsigned A*B+C at full 2P-bit result width
package SysVerParam;

  localparam int unsigned P        = 8;
  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned LAT      = 3;

  typedef logic [$clog2(NREQ_DEF)-1:0] tag_t;
  typedef logic [P-1:0]                opnd_t;
  typedef logic [2*P-1:0]              res_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_t;

  // Operands are zero-extended before the multiply so nothing is truncated;
  // (2^P-1)^2 + (2^P-1) always fits in 2P bits.
  function automatic res_t mac_calc(opnd_t a, opnd_t b, opnd_t c);
    return res_t'(a) * res_t'(b) + res_t'(c);
  endfunction

endpackage

// File: rtl/mac_arbiter_pipe.sv
// mac_pipe: three-stage A*B+C datapath with a tag/valid sideband.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_valid, i_tag      : operation accepted this edge, and its requester tag
//   i_a, i_b, i_c       : operands
//   o_valid, o_tag      : result valid and the tag it belongs to
//   o_data              : A*B+C, held while o_valid is low
//   o_busy              : any stage holds a valid operation
// Stage 1 registers operands, stage 2 registers the sum, stage 3 is the
// output register, giving LAT = 3.
module mac_pipe
  import SysVerParam::*;
#(
  parameter int unsigned TW = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  input  logic [TW-1:0]  i_tag,
  input  logic [P-1:0]   i_a,
  input  logic [P-1:0]   i_b,
  input  logic [P-1:0]   i_c,
  output logic           o_valid,
  output logic [TW-1:0]  o_tag,
  output logic [2*P-1:0] o_data,
  output logic           o_busy
);

  logic           r_s1_v;
  logic [TW-1:0]  r_s1_tag;
  logic [P-1:0]   r_s1_a;
  logic [P-1:0]   r_s1_b;
  logic [P-1:0]   r_s1_c;

  logic           r_s2_v;
  logic [TW-1:0]  r_s2_tag;
  logic [2*P-1:0] r_s2_sum;

  logic           r_s3_v;
  logic [TW-1:0]  r_s3_tag;
  logic [2*P-1:0] r_s3_data;

  // Stage 1: operand capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_v   <= 1'b0;
      r_s1_tag <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_c   <= '0;
    end else begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_tag <= i_tag;
        r_s1_a   <= i_a;
        r_s1_b   <= i_b;
        r_s1_c   <= i_c;
      end
    end
  end

  // Stage 2: multiply-add.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_v   <= 1'b0;
      r_s2_tag <= '0;
      r_s2_sum <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_tag <= r_s1_tag;
        r_s2_sum <= mac_calc(r_s1_a, r_s1_b, r_s1_c);
      end
    end
  end

  // Stage 3: output register; data only loads on a valid so it holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s3_v    <= 1'b0;
      r_s3_tag  <= '0;
      r_s3_data <= '0;
    end else begin
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_s3_tag  <= r_s2_tag;
        r_s3_data <= r_s2_sum;
      end
    end
  end

  assign o_valid = r_s3_v;
  assign o_tag   = r_s3_tag;
  assign o_data  = r_s3_data;
  assign o_busy  = r_s1_v | r_s2_v | r_s3_v;

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin sharing of one pipelined A*B+C unit.
//   C, R       : clock, asynchronous active-high reset
//   req_valid  : per-requester request
//   req_a/b/c  : packed operands, requester i at [i*P +: P]
//   req_ready  : one-hot grant (transfer on valid & ready)
//   flush      : level; stop granting and drain the pipeline
//   res_valid  : one-hot result strobe back to the issuing requester
//   res_data   : A*B+C, holds when res_valid is low
//   busy       : any operation in flight
//   drained    : one-cycle pulse when a drain completes
module mac_arbiter
  import SysVerParam::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic              C,
  input  logic              R,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*P-1:0] req_a,
  input  logic [NREQ*P-1:0] req_b,
  input  logic [NREQ*P-1:0] req_c,
  output logic [NREQ-1:0]   req_ready,
  input  logic              flush,
  output logic [NREQ-1:0]   res_valid,
  output logic [2*P-1:0]    res_data,
  output logic              busy,
  output logic              drained
);

  localparam int unsigned TW = $clog2(NREQ);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [TW-1:0]  r_ptr;
  logic           r_drain_done;

  logic [NREQ-1:0] w_below;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;
  logic [NREQ-1:0] w_gnt;
  logic            w_accept_ok;
  logic            w_xfer;
  logic            w_empty;
  logic            w_drained;
  logic [TW-1:0]   w_tag;

  logic [P-1:0]    w_a_arr [NREQ];
  logic [P-1:0]    w_b_arr [NREQ];
  logic [P-1:0]    w_c_arr [NREQ];

  logic            w_p_valid;
  logic [TW-1:0]   w_p_tag;
  logic [2*P-1:0]  w_p_data;
  logic            w_p_busy;

  for (genvar g = 0; g < NREQ; g++) begin : g_opnd
    assign w_a_arr[g] = req_a[g*P +: P];
    assign w_b_arr[g] = req_b[g*P +: P];
    assign w_c_arr[g] = req_c[g*P +: P];
  end

  // Round-robin as two priority passes: first the requests at or above the
  // pointer, otherwise all requests (the wrap). x & -x isolates the lowest bit.
  always_comb begin
    w_below     = (NREQ'(1) << r_ptr) - NREQ'(1);
    w_hi        = req_valid & ~w_below;
    w_sel       = (|w_hi) ? w_hi : req_valid;
    w_accept_ok = !R && !flush && (r_state != DRAIN);
    w_gnt       = w_accept_ok ? (w_sel & (~w_sel + NREQ'(1))) : '0;
  end

  always_comb begin
    w_tag = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (w_gnt[j[TW-1:0]]) w_tag = j[TW-1:0];
    end
  end

  // Grants are a subset of req_valid, so any grant is a transfer.
  assign w_xfer    = |w_gnt;
  assign req_ready = w_gnt;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_tag == TW'(NREQ - 1)) ? '0 : w_tag + TW'(1);
    end
  end

  mac_pipe #(
    .TW (TW)
  ) u_pipe (
    .i_clk   (C),
    .i_rst   (R),
    .i_valid (w_xfer),
    .i_tag   (w_tag),
    .i_a     (w_a_arr[w_tag]),
    .i_b     (w_b_arr[w_tag]),
    .i_c     (w_c_arr[w_tag]),
    .o_valid (w_p_valid),
    .o_tag   (w_p_tag),
    .o_data  (w_p_data),
    .o_busy  (w_p_busy)
  );

  assign w_empty   = !w_p_busy;
  assign busy      = w_p_busy;
  assign res_data  = w_p_data;
  assign res_valid = w_p_valid ? (NREQ'(1) << w_p_tag) : '0;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state      <= IDLE;
      r_drain_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Remember the pulse for the rest of this DRAIN visit only.
      if (w_drained) begin
        r_drain_done <= 1'b1;
      end else if (r_state != DRAIN) begin
        r_drain_done <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drained   = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_state_nxt = DRAIN;
        end else if (|req_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          w_state_nxt = DRAIN;
        end else if (!(|req_valid) && w_empty) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (w_empty && !r_drain_done) w_drained = 1'b1;
        if (w_empty && !flush) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign drained = w_drained;

endmodule
